// File: rtl/alu_pkg.sv
// ============================================================================
// Module : alu_pkg
// Brief  : Shared encodings for the multi-cycle Y86 ALU.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

package alu_pkg;

    localparam logic [1:0] ALU_ADD = 2'b00;
    localparam logic [1:0] ALU_SUB = 2'b01;
    localparam logic [1:0] ALU_AND = 2'b10;
    localparam logic [1:0] ALU_XOR = 2'b11;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_DONE = 2'd2
    } state_t;

    localparam int CC_ZF = 2;
    localparam int CC_SF = 1;
    localparam int CC_OF = 0;

endpackage

`default_nettype wire

// File: rtl/alu_slice.sv
// ============================================================================
// Module : alu_slice
// Brief  : Combinational CHUNK-bit ALU slice shared across all chunk cycles.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module alu_slice
    import alu_pkg::*;
#(
    parameter int CHUNK = 16
) (
    input  logic [CHUNK-1:0] a,
    input  logic [CHUNK-1:0] b,
    input  logic             cin,
    input  logic [1:0]       op,
    output logic [CHUNK-1:0] r,
    output logic             cout
);

    logic [CHUNK:0] w_sum;

    // b arrives pre-inverted for SUB, so ADD and SUB share the adder
    assign w_sum = {1'b0, a} + {1'b0, b} + {{CHUNK{1'b0}}, cin};

    always_comb begin
        r    = w_sum[CHUNK-1:0];
        cout = w_sum[CHUNK];
        case (op)
            ALU_AND: begin
                r    = a & b;
                cout = 1'b0;
            end
            ALU_XOR: begin
                r    = a ^ b;
                cout = 1'b0;
            end
            default: ;
        endcase
    end

endmodule

`default_nettype wire

// File: rtl/alu_multicycle.sv
// ============================================================================
// Module : alu_multicycle
// Brief  : Chunk-serial ADD/SUB/AND/XOR with valid/ready handshakes and flags.
//          Define ALU_CC_EN to add the persistent condition-code output cc.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module alu_multicycle
    import alu_pkg::*;
#(
    parameter int WIDTH = 64,
    parameter int CHUNK = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] num1,
    input  logic [WIDTH-1:0] num2,
    input  logic [1:0]       operation,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             overflow_flag,
    output logic             zero_flag,
    output logic             sign_flag,
    output logic             busy
`ifdef ALU_CC_EN
    ,
    output logic [2:0]       cc
`endif
);

    localparam int NCHUNK = WIDTH / CHUNK;
    localparam int KW     = $clog2(NCHUNK + 1);
    // Counter value reached once every slice has been written: flag phase
    localparam logic [KW-1:0] C_FLAG_PHASE = KW'(NCHUNK);

    state_t           r_state;
    logic [KW-1:0]    r_k;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [1:0]       r_op;
    logic             r_carry;
    logic             r_sa;
    logic             r_sb;
    logic [WIDTH-1:0] r_result;
    logic             r_of;
    logic             r_zf;
    logic             r_sf;
    logic             r_in_ready;
    logic             r_out_valid;
    logic             r_busy;

    logic [CHUNK-1:0] w_r;
    logic             w_cout;
    logic [WIDTH-1:0] w_result_nxt;
    logic             w_arith;

    alu_slice #(.CHUNK(CHUNK)) u_slice (
        .a    (r_a[CHUNK-1:0]),
        .b    (r_b[CHUNK-1:0]),
        .cin  (r_carry),
        .op   (r_op),
        .r    (w_r),
        .cout (w_cout)
    );

    // Operands shift down each cycle; slice output enters the result at the top
    generate
        if (NCHUNK == 1) begin : g_single
            assign w_result_nxt = w_r;
        end else begin : g_multi
            assign w_result_nxt = {w_r, r_result[WIDTH-1:CHUNK]};
        end
    endgenerate

    assign w_arith = (r_op == ALU_ADD) || (r_op == ALU_SUB);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_k         <= '0;
            r_a         <= '0;
            r_b         <= '0;
            r_op        <= ALU_ADD;
            r_carry     <= 1'b0;
            r_sa        <= 1'b0;
            r_sb        <= 1'b0;
            r_result    <= '0;
            r_of        <= 1'b0;
            r_zf        <= 1'b0;
            r_sf        <= 1'b0;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
            r_busy      <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (in_valid) begin
                        r_a        <= num1;
                        r_b        <= (operation == ALU_SUB) ? ~num2 : num2;
                        r_carry    <= (operation == ALU_SUB);
                        r_op       <= operation;
                        r_sa       <= num1[WIDTH-1];
                        r_sb       <= (operation == ALU_SUB) ? ~num2[WIDTH-1] : num2[WIDTH-1];
                        r_k        <= '0;
                        r_state    <= S_BUSY;
                        r_in_ready <= 1'b0;
                        r_busy     <= 1'b1;
                    end
                end
                S_BUSY: begin
                    if (r_k != C_FLAG_PHASE) begin
                        r_result <= w_result_nxt;
                        r_a      <= r_a >> CHUNK;
                        r_b      <= r_b >> CHUNK;
                        r_carry  <= w_cout;
                        r_k      <= r_k + 1'b1;
                    end else begin
                        // r_sb holds the sign of the operand actually added,
                        // so one overflow rule covers both ADD and SUB
                        r_of        <= w_arith && (r_sa == r_sb) &&
                                       (r_result[WIDTH-1] != r_sa);
                        r_zf        <= (r_result == '0);
                        r_sf        <= r_result[WIDTH-1];
                        r_out_valid <= 1'b1;
                        r_state     <= S_DONE;
                    end
                end
                S_DONE: begin
                    if (out_ready) begin
                        r_out_valid <= 1'b0;
                        r_in_ready  <= 1'b1;
                        r_busy      <= 1'b0;
                        r_state     <= S_IDLE;
                    end
                end
                default: begin
                    r_state     <= S_IDLE;
                    r_in_ready  <= 1'b1;
                    r_out_valid <= 1'b0;
                    r_busy      <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready      = r_in_ready;
    assign out_valid     = r_out_valid;
    assign result        = r_result;
    assign overflow_flag = r_of;
    assign zero_flag     = r_zf;
    assign sign_flag     = r_sf;
    assign busy          = r_busy;

`ifdef ALU_CC_EN
    logic [2:0] r_cc;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cc <= 3'b100;
        end else if (r_out_valid && out_ready) begin
            r_cc[CC_ZF] <= r_zf;
            r_cc[CC_SF] <= r_sf;
            r_cc[CC_OF] <= r_of;
        end
    end

    assign cc = r_cc;
`endif

endmodule

`default_nettype wire
